// File: rtl/id_ex_reg.sv
// Decode/Execute pipeline register with load-use bubble insertion, EX back-pressure,
// branch flush, writeback refresh of held operands and a saturating bubble counter.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              wb_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d;
  logic [4:0]        rs2_q, rs2_d;
  logic [4:0]        rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_read_q, mem_read_d;
  logic              reg_write_q, reg_write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic load_use;
  logic rs1_match;
  logic rs2_match;
  logic cnt_sat;

  // Register 0 is an ordinary register here; no r0 exclusion on any compare.
  assign rs1_match = id_uses_rs1 && (id_rs1 == rd_q);
  assign rs2_match = id_uses_rs2 && (id_rs2 == rd_q);
  assign load_use  = id_valid && valid_q && mem_read_q && (rs1_match || rs2_match);

  assign hazard_stall = !flush && (ex_stall || load_use);
  assign cnt_sat      = &cnt_q;

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    cnt_d       = cnt_q;

    if (flush || (!ex_stall && load_use)) begin
      // Kill or bubble: payload fields are don't-care, so take them from ID.
      valid_d     = 1'b0;
      pc_d        = id_pc;
      rd1_d       = id_rd1;
      rd2_d       = id_rd2;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      ctrl_d      = id_ctrl;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
      if (!flush && !cnt_sat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ex_stall) begin
      // Held operands would go stale if WB retires a producer while EX is busy.
      if (wb_write && (wb_rd == rs1_q)) begin
        rd1_d = wb_data;
      end
      if (wb_write && (wb_rd == rs2_q)) begin
        rd2_d = wb_data;
      end
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rd1_d       = id_rd1;
      rd2_d       = id_rd2;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      ctrl_d      = id_ctrl;
      mem_read_d  = id_valid && id_mem_read;
      reg_write_d = id_valid && id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, pass-through, load-use bubble, stall with WB refresh,
// flush priority, counter saturation (CNT_W=4) and reset during a stall.
module tb_id_ex_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [4:0]        id_rs1, id_rs2;
  logic              id_uses_rs1, id_uses_rs2;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_read, id_reg_write;
  logic              flush, ex_stall, wb_write;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_read, ex_reg_write, hazard_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_rd1      (id_rd1),
    .id_rd2      (id_rd2),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .id_mem_read (id_mem_read),
    .id_reg_write(id_reg_write),
    .flush       (flush),
    .ex_stall    (ex_stall),
    .wb_write    (wb_write),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .ex_rd       (ex_rd),
    .ex_ctrl     (ex_ctrl),
    .ex_mem_read (ex_mem_read),
    .ex_reg_write(ex_reg_write),
    .hazard_stall(hazard_stall),
    .bubble_cnt  (bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_ctrl = '0;
    id_mem_read = 0; id_reg_write = 0;
  endtask

  task automatic put_load(input logic [DATA_W-1:0] pc);
    clear_id();
    id_valid = 1; id_pc = pc; id_rd = 5'd5; id_mem_read = 1; id_reg_write = 1;
  endtask

  task automatic put_consumer_rs1(input logic [DATA_W-1:0] pc);
    clear_id();
    id_valid = 1; id_pc = pc; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rd = 5'd6; id_reg_write = 1;
  endtask

  initial begin
    // Reset with every input nonzero
    rst = 1; id_valid = 1; id_pc = 32'hFFFF_FFFC; id_rs1 = 5'd31; id_rs2 = 5'd30;
    id_uses_rs1 = 1; id_uses_rs2 = 1; id_rd = 5'd29; id_rd1 = 32'h1111_1111;
    id_rd2 = 32'h2222_2222; id_imm = 32'h3333_3333; id_ctrl = 16'hA5A5;
    id_mem_read = 1; id_reg_write = 1; flush = 1; ex_stall = 1; wb_write = 1;
    wb_rd = 5'd31; wb_data = 32'h4444_4444;
    step();
    check("rst_valid", ex_valid, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_rd1", ex_rd1, 0);
    check("rst_imm", ex_imm, 0);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_mem_read", ex_mem_read, 0);
    check("rst_reg_write", ex_reg_write, 0);
    check("rst_cnt", bubble_cnt, 0);
    flush = 0; ex_stall = 0; wb_write = 0;
    #1;
    check("rst_hazard", hazard_stall, 0);

    // Pass-through
    rst = 0; clear_id();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd1 = 32'h1234;
    id_imm = 32'hFFFF_FFF0; id_rd = 5'd7; id_reg_write = 1; id_ctrl = 16'h0042;
    step();
    check("pt_valid", ex_valid, 1);
    check("pt_rd1", ex_rd1, 32'h1234);
    check("pt_imm", ex_imm, 32'hFFFF_FFF0);
    check("pt_rd", ex_rd, 7);
    check("pt_reg_write", ex_reg_write, 1);
    check("pt_pc", ex_pc, 32'h100);
    check("pt_ctrl", ex_ctrl, 16'h0042);
    check("pt_mem_read", ex_mem_read, 0);

    // Load-use on rs2
    put_load(32'h104);
    step();
    check("lu_load_in_ex", ex_mem_read, 1);
    clear_id();
    id_valid = 1; id_pc = 32'h108; id_rs1 = 5'd3; id_uses_rs1 = 1; id_rs2 = 5'd5;
    id_uses_rs2 = 1; id_rd = 5'd6; id_rd2 = 32'hAAAA; id_reg_write = 1;
    #1;
    check("lu_hazard", hazard_stall, 1);
    step();
    check("lu_bub_valid", ex_valid, 0);
    check("lu_bub_mem_read", ex_mem_read, 0);
    check("lu_bub_reg_write", ex_reg_write, 0);
    check("lu_cnt", bubble_cnt, 1);
    check("lu_hazard_clear", hazard_stall, 0);
    step();
    check("lu_cons_valid", ex_valid, 1);
    check("lu_cons_pc", ex_pc, 32'h108);
    check("lu_cons_rd2", ex_rd2, 32'hAAAA);

    // Same pair but rs2 not actually read -> no stall
    put_load(32'h10C);
    step();
    clear_id();
    id_valid = 1; id_pc = 32'h110; id_rs1 = 5'd3; id_uses_rs1 = 1; id_rs2 = 5'd5;
    id_uses_rs2 = 0; id_rd = 5'd6;
    #1;
    check("nolu_hazard", hazard_stall, 0);
    step();
    check("nolu_valid", ex_valid, 1);
    check("nolu_pc", ex_pc, 32'h110);
    check("nolu_cnt", bubble_cnt, 1);

    // EX back-pressure with WB refresh
    clear_id();
    id_valid = 1; id_pc = 32'h200; id_rs1 = 5'd9; id_rs2 = 5'd9; id_rd1 = 32'h11;
    id_rd2 = 32'h22; id_rd = 5'd10; id_ctrl = 16'hBEEF; id_reg_write = 1;
    step();
    clear_id();
    id_valid = 1; id_pc = 32'h204; id_rd1 = 32'h33; id_rd = 5'd11; id_ctrl = 16'h1234;
    ex_stall = 1;
    #1;
    check("st_hazard1", hazard_stall, 1);
    step();
    check("st_rd1_before_wb", ex_rd1, 32'h11);
    wb_write = 1; wb_rd = 5'd9; wb_data = 32'hCAFE;
    #1;
    check("st_hazard2", hazard_stall, 1);
    step();
    wb_write = 0; wb_data = 32'h0;
    check("st_rd1_refresh", ex_rd1, 32'hCAFE);
    check("st_rd2_refresh", ex_rd2, 32'hCAFE);
    #1;
    check("st_hazard3", hazard_stall, 1);
    step();
    check("st_pc_held", ex_pc, 32'h200);
    check("st_ctrl_held", ex_ctrl, 16'hBEEF);
    check("st_rd_held", ex_rd, 10);
    check("st_valid_held", ex_valid, 1);
    check("st_rd1_kept", ex_rd1, 32'hCAFE);
    ex_stall = 0;
    step();
    check("st_release_pc", ex_pc, 32'h204);

    // Flush beats ex_stall and load-use
    put_load(32'h300);
    step();
    put_consumer_rs1(32'h304);
    ex_stall = 1; flush = 1;
    #1;
    check("fl_hazard", hazard_stall, 0);
    step();
    check("fl_valid", ex_valid, 0);
    check("fl_mem_read", ex_mem_read, 0);
    check("fl_reg_write", ex_reg_write, 0);
    check("fl_cnt", bubble_cnt, 1);
    flush = 0; ex_stall = 0;

    // 17 more load-use bubbles; 4-bit counter saturates at 0xF
    for (int i = 0; i < 17; i++) begin
      put_load(32'h400 + 8 * i);
      step();
      put_consumer_rs1(32'h404 + 8 * i);
      step();
      if (i == 0) check("sat_cnt_2", bubble_cnt, 2);
      if (i == 5) check("sat_cnt_7", bubble_cnt, 7);
      if (i == 13) check("sat_cnt_f", bubble_cnt, 4'hF);
    end
    check("sat_cnt_end", bubble_cnt, 4'hF);

    // Reset during a stall
    clear_id();
    id_valid = 1; id_pc = 32'h500; id_rd = 5'd12;
    step();
    ex_stall = 1; rst = 1;
    step();
    rst = 0;
    #1;
    check("rs_valid", ex_valid, 0);
    check("rs_cnt", bubble_cnt, 0);
    check("rs_pc", ex_pc, 0);
    check("rs_hazard_stall_in", hazard_stall, 1);
    ex_stall = 0;
    #1;
    check("rs_hazard_idle", hazard_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
